fpmul_pipe: RTL and testbench

- Parametrised, pipelined IEEE 754 binary floating-point multiplier.
- Generalises the team's single-precision combinational multiplier:
  - configurable exponent and fraction widths
  - round-to-nearest-even
  - special-value handling and exception flags
  - valid/ready streaming with backpressure.
- Sits between operand-issue logic and result writeback in the FP datapath. One result per cycle when not stalled.

---
 rtl/fp_pkg.sv | 39 +++
 rtl/fp_round_pack.sv | 65 ++++++
 rtl/fpmul_pipe.sv | 196 +++++++++++++++++++
 tb/tb_fpmul_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the parametrised floating-point datapath:
// operand classes, exception flag bit positions and format constants.
package fp_pkg;

    // Operand classification produced by the unpack stage.
    typedef enum logic [2:0] {
        ZERO,
        SUB,
        NORM,
        INF,
        QNAN,
        SNAN
    } fp_class_e;

    // Bit positions inside the 5-bit exception flag vector.
    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_DIVZERO   = 3;
    localparam int FLAG_INVALID   = 4;

    // Exponent bias for an exp_w-bit exponent field.
    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN, right-aligned in a wide vector; callers keep
    // the low 1+exp_w+frac_w bits.
    function automatic logic [127:0] fp_qnan(input int exp_w, input int frac_w);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) begin
            r[frac_w + i] = 1'b1;
        end
        r[frac_w - 1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalise, round-to-nearest-even and pack a raw significand product.
// Purely combinational; overflow saturates to signed infinity and
// underflow flushes to signed zero.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                        sign,
    input  logic [EXP_W+1:0]            exp_in,   // two's-complement biased exponent
    input  logic [2*(FRAC_W+1)-1:0]     prod,
    output logic [EXP_W+FRAC_W:0]       result,
    output logic [4:0]                  flags
);

    localparam int P  = 2 * (FRAC_W + 1);
    localparam int EW = EXP_W + 2;

    logic              msb;
    logic [FRAC_W-1:0] frac_t;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [FRAC_W:0]   frac_r;
    logic [EW-1:0]     exp_n;
    logic [EW-1:0]     exp_f;
    logic              ovf;
    logic              unf;

    // Normalise to a leading one, round, then range-check the exponent.
    always_comb begin
        msb = prod[P-1];
        if (msb) begin
            frac_t = prod[P-2 -: FRAC_W];
            guard  = prod[FRAC_W];
            sticky = |prod[FRAC_W-1:0];
        end else begin
            frac_t = prod[P-3 -: FRAC_W];
            guard  = prod[FRAC_W-1];
            sticky = |prod[FRAC_W-2:0];
        end
        inc    = guard & (sticky | frac_t[0]);
        frac_r = {1'b0, frac_t} + {{FRAC_W{1'b0}}, inc};
        exp_n  = exp_in + {{(EW-1){1'b0}}, msb};
        // A rounding carry leaves the fraction at zero and bumps the exponent.
        exp_f  = exp_n + {{(EW-1){1'b0}}, frac_r[FRAC_W]};
        ovf    = !exp_f[EW-1] && (exp_f[EW-2:0] >= {1'b0, {EXP_W{1'b1}}});
        unf    = exp_f[EW-1] || (exp_f == '0);

        result = {sign, exp_f[EXP_W-1:0], frac_r[FRAC_W-1:0]};
        flags  = '0;
        flags[FLAG_INEXACT] = guard | sticky;
        if (ovf) begin
            result = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags[FLAG_OVERFLOW] = 1'b1;
            flags[FLAG_INEXACT]  = 1'b1;
        end else if (unf) begin
            result = {sign, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
            flags[FLAG_UNDERFLOW] = 1'b1;
            flags[FLAG_INEXACT]   = 1'b1;
        end
    end

endmodule

// File: rtl/fpmul_pipe.sv
// Three-stage pipelined IEEE 754 multiplier: S1 unpack/classify,
// S2 significand multiply, S3 round/pack into the output registers.
//
// Handshake: a transfer happens on a clock edge where valid && ready on
// that side. The pipe stalls as a whole when out_valid && !out_ready;
// in_ready is the inverse of that stall and never looks at in_valid.
// While stalled every stage (including empty ones) holds its contents.
module fpmul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int TAG_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+FRAC_W:0]  in_a,
    input  logic [EXP_W+FRAC_W:0]  in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+FRAC_W:0]  out_result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [4:0]             out_flags
);

    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int P  = 2 * (FRAC_W + 1);
    localparam int EW = EXP_W + 2;

    localparam int             BIAS       = fp_bias(EXP_W);
    localparam logic [EW-1:0]  BIAS_V     = BIAS[EW-1:0];
    localparam logic [127:0]   QNAN_WIDE  = fp_qnan(EXP_W, FRAC_W);
    localparam logic [W-1:0]   QNAN_V     = QNAN_WIDE[W-1:0];

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                           input logic [FRAC_W-1:0] f);
        if (e == '0) begin
            return (f == '0) ? ZERO : SUB;
        end else if (&e) begin
            if (f == '0) return INF;
            return f[FRAC_W-1] ? QNAN : SNAN;
        end
        return NORM;
    endfunction

    logic advance;

    // S1 combinational signals
    fp_class_e       cls_a, cls_b;
    logic            a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic            sign_c;
    logic            spec_c;
    logic [W-1:0]    spec_res_c;
    logic [4:0]      spec_flags_c;
    logic [EW-1:0]   exp_sum_c;

    // S1 registers
    logic              s1_valid;
    logic              s1_sign;
    logic [EW-1:0]     s1_exp;
    logic [FRAC_W:0]   s1_sig_a, s1_sig_b;
    logic              s1_spec;
    logic [W-1:0]      s1_spec_res;
    logic [4:0]        s1_spec_flags;
    logic [TAG_W-1:0]  s1_tag;

    // S2 registers
    logic              s2_valid;
    logic              s2_sign;
    logic [EW-1:0]     s2_exp;
    logic [P-1:0]      s2_prod;
    logic              s2_spec;
    logic [W-1:0]      s2_spec_res;
    logic [4:0]        s2_spec_flags;
    logic [TAG_W-1:0]  s2_tag;

    // S3 combinational result
    logic [W-1:0]      rp_result;
    logic [4:0]        rp_flags;

    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    // Classify operands and resolve special cases ahead of the arithmetic path.
    always_comb begin
        cls_a  = classify(in_a[W-2:FRAC_W], in_a[FRAC_W-1:0]);
        cls_b  = classify(in_b[W-2:FRAC_W], in_b[FRAC_W-1:0]);
        a_nan  = (cls_a == QNAN) || (cls_a == SNAN);
        b_nan  = (cls_b == QNAN) || (cls_b == SNAN);
        a_inf  = (cls_a == INF);
        b_inf  = (cls_b == INF);
        // Subnormals are treated as zero on input.
        a_zero = (cls_a == ZERO) || (cls_a == SUB);
        b_zero = (cls_b == ZERO) || (cls_b == SUB);
        sign_c = in_a[W-1] ^ in_b[W-1];

        spec_c       = 1'b0;
        spec_res_c   = '0;
        spec_flags_c = '0;
        if (a_nan || b_nan) begin
            spec_c     = 1'b1;
            spec_res_c = QNAN_V;
            spec_flags_c[FLAG_INVALID] = (cls_a == SNAN) || (cls_b == SNAN);
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_c     = 1'b1;
            spec_res_c = QNAN_V;
            spec_flags_c[FLAG_INVALID] = 1'b1;
        end else if (a_inf || b_inf) begin
            spec_c     = 1'b1;
            spec_res_c = {sign_c, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            spec_c     = 1'b1;
            spec_res_c = {sign_c, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
        end

        exp_sum_c = {2'b00, in_a[W-2:FRAC_W]} + {2'b00, in_b[W-2:FRAC_W]} - BIAS_V;
    end

    // S1: register unpacked operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_sign       <= 1'b0;
            s1_exp        <= '0;
            s1_sig_a      <= '0;
            s1_sig_b      <= '0;
            s1_spec       <= 1'b0;
            s1_spec_res   <= '0;
            s1_spec_flags <= '0;
            s1_tag        <= '0;
        end else if (advance) begin
            s1_valid      <= in_valid;
            s1_sign       <= sign_c;
            s1_exp        <= exp_sum_c;
            s1_sig_a      <= {1'b1, in_a[FRAC_W-1:0]};
            s1_sig_b      <= {1'b1, in_b[FRAC_W-1:0]};
            s1_spec       <= spec_c;
            s1_spec_res   <= spec_res_c;
            s1_spec_flags <= spec_flags_c;
            s1_tag        <= in_tag;
        end
    end

    // S2: full-width significand product.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid      <= 1'b0;
            s2_sign       <= 1'b0;
            s2_exp        <= '0;
            s2_prod       <= '0;
            s2_spec       <= 1'b0;
            s2_spec_res   <= '0;
            s2_spec_flags <= '0;
            s2_tag        <= '0;
        end else if (advance) begin
            s2_valid      <= s1_valid;
            s2_sign       <= s1_sign;
            s2_exp        <= s1_exp;
            s2_prod       <= {{(FRAC_W+1){1'b0}}, s1_sig_a} * {{(FRAC_W+1){1'b0}}, s1_sig_b};
            s2_spec       <= s1_spec;
            s2_spec_res   <= s1_spec_res;
            s2_spec_flags <= s1_spec_flags;
            s2_tag        <= s1_tag;
        end
    end

    fp_round_pack #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_round_pack (
        .sign   (s2_sign),
        .exp_in (s2_exp),
        .prod   (s2_prod),
        .result (rp_result),
        .flags  (rp_flags)
    );

    // S3: select special or rounded result into the output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_flags  <= '0;
        end else if (advance) begin
            out_valid  <= s2_valid;
            out_result <= s2_spec ? s2_spec_res : rp_result;
            out_tag    <= s2_tag;
            out_flags  <= s2_spec ? s2_spec_flags : rp_flags;
        end
    end

endmodule

// File: tb/tb_fpmul_pipe.sv
// Directed bench for fpmul_pipe (single precision): reset state, single
// products with hand-computed results, streaming with backpressure and
// reset in the middle of a stream.
module tb_fpmul_pipe;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int TAG_W  = 4;
    localparam int W      = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_result;
    logic [TAG_W-1:0] out_tag;
    logic [4:0]       out_flags;

    int total = 0;
    int bad   = 0;

    logic [W+TAG_W-1:0] exp_q[$];

    // Clock and reset
    always #5 clk = ~clk;

    fpmul_pipe #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W),
        .TAG_W  (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    // Stream operand B values 1.0 .. 8.0 and products with A = 2.0.
    function automatic logic [W-1:0] b_of(input int i);
        case (i)
            0: return 32'h3F800000;
            1: return 32'h40000000;
            2: return 32'h40400000;
            3: return 32'h40800000;
            4: return 32'h40A00000;
            5: return 32'h40C00000;
            6: return 32'h40E00000;
            default: return 32'h41000000;
        endcase
    endfunction

    function automatic logic [W-1:0] p_of(input int i);
        case (i)
            0: return 32'h40000000;
            1: return 32'h40800000;
            2: return 32'h40C00000;
            3: return 32'h41000000;
            4: return 32'h41200000;
            5: return 32'h41400000;
            6: return 32'h41600000;
            default: return 32'h41800000;
        endcase
    endfunction

    // Driver: one operation, checks exact 3-cycle latency and the result.
    task automatic run_single(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [TAG_W-1:0] tag, input logic [W-1:0] exp_res,
                              input logic [4:0] exp_flags);
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = 1'b1;
        #1;
        check({name, "_in_ready"}, 64'(in_ready), 64'(1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_lat1"}, 64'(out_valid), 64'(1'b0));
        @(negedge clk);
        check({name, "_lat2"}, 64'(out_valid), 64'(1'b0));
        @(negedge clk);
        check({name, "_valid"}, 64'(out_valid), 64'(1'b1));
        check({name, "_result"}, 64'(out_result), 64'(exp_res));
        check({name, "_flags"}, 64'(out_flags), 64'(exp_flags));
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
    endtask

    // Driver + scoreboard: 8 ops, 4-cycle stall mid-stream, optional reset.
    task automatic run_stream(input bit do_reset, input string name);
        int               sent = 0;
        int               got  = 0;
        int               cyc  = 0;
        bit               stalled = 1'b0;
        logic [W-1:0]     hold_res = '0;
        logic [TAG_W-1:0] hold_tag = '0;
        logic [W+TAG_W-1:0] e;
        exp_q.delete();
        while ((sent < 8 || exp_q.size() != 0) && cyc < 60) begin
            @(negedge clk);
            in_valid  = (sent < 8);
            in_a      = 32'h40000000;
            in_b      = b_of(sent);
            in_tag    = sent[TAG_W-1:0];
            out_ready = !(cyc >= 5 && cyc < 9);
            rst       = do_reset && (cyc == 6);
            #1;
            if (rst) begin
                exp_q.delete();
                sent = 8;
                @(posedge clk);
                #1;
                rst      = 1'b0;
                in_valid = 1'b0;
                out_ready = 1'b1;
            end else begin
                if (out_valid && !out_ready) begin
                    check({name, "_stall_in_ready"}, 64'(in_ready), 64'(1'b0));
                    if (stalled) begin
                        check({name, "_stall_result"}, 64'(out_result), 64'(hold_res));
                        check({name, "_stall_tag"}, 64'(out_tag), 64'(hold_tag));
                    end
                    stalled  = 1'b1;
                    hold_res = out_result;
                    hold_tag = out_tag;
                end else begin
                    stalled = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check({name, "_unexpected_out"}, 64'(out_tag), 64'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check({name, "_out"}, 64'({out_tag, out_result}), 64'(e));
                        got++;
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back({sent[TAG_W-1:0], p_of(sent)});
                    sent++;
                end
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({name, "_no_timeout"}, 64'(cyc < 60), 64'(1'b1));
        if (!do_reset) begin
            check({name, "_count"}, 64'(got), 64'(8));
        end else begin
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                check({name, "_post_reset_idle"}, 64'(out_valid), 64'(1'b0));
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1'b1));
        check("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check("rst_out_result", 64'(out_result), 64'(0));
        check("rst_out_tag", 64'(out_tag), 64'(0));
        check("rst_out_flags", 64'(out_flags), 64'(0));
        rst = 1'b0;

        run_single("basic",      32'h3FC00000, 32'h40000000, 4'd1, 32'h40400000, 5'b00000);
        run_single("round",      32'h3F800001, 32'h3F800001, 4'd2, 32'h3F800002, 5'b00001);
        run_single("tie_up",     32'h3FC00000, 32'h3F800001, 4'd3, 32'h3FC00002, 5'b00001);
        run_single("tie_even",   32'h3FC00000, 32'h3F800003, 4'd4, 32'h3FC00004, 5'b00001);
        run_single("rnd_carry",  32'h3F800001, 32'h3FFFFFFE, 4'd5, 32'h40000000, 5'b00001);
        run_single("negative",   32'hC0000000, 32'h40400000, 4'd6, 32'hC0C00000, 5'b00000);
        run_single("overflow",   32'h7F000000, 32'h7F000000, 4'd7, 32'h7F800000, 5'b00101);
        run_single("underflow",  32'h00800000, 32'h3F000000, 4'd8, 32'h00000000, 5'b00011);
        run_single("inf_zero",   32'h7F800000, 32'h80000000, 4'd9, 32'h7FC00000, 5'b10000);
        run_single("snan",       32'h7F800001, 32'h3F800000, 4'd10, 32'h7FC00000, 5'b10000);
        run_single("qnan",       32'h7FC00000, 32'h3F800000, 4'd11, 32'h7FC00000, 5'b00000);
        run_single("inf_fin",    32'h7F800000, 32'hC0000000, 4'd12, 32'hFF800000, 5'b00000);
        run_single("zero_fin",   32'hBF800000, 32'h00000000, 4'd13, 32'h80000000, 5'b00000);
        run_single("daz",        32'h00000001, 32'h40000000, 4'd14, 32'h00000000, 5'b00000);

        run_stream(1'b0, "stream");
        run_stream(1'b1, "stream_rst");
        run_single("after_rst",  32'h3FC00000, 32'h40000000, 4'd15, 32'h40400000, 5'b00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
